// File: rtl/cdb_fill_arbiter.sv
// Arbitrates instruction-fetch and data fill requests onto one DMA read channel,
// then steers the returned line to the instruction or data store.
module cdb_fill_arbiter #(
  parameter int INW     = 512,
  parameter int ADDRW   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifetch_req,
  input  logic [ADDRW-1:0] ifetch_addr,
  output logic             ifetch_gnt,
  input  logic             dmem_req,
  input  logic [ADDRW-1:0] dmem_addr,
  output logic             dmem_gnt,
  input  logic             dma_ready,
  output logic             dma_rd_req,
  output logic [ADDRW-1:0] dma_addr,
  input  logic             rd_valid,
  input  logic [INW-1:0]   common_data_bus_in,
  output logic [INW-1:0]   line_out,
  output logic             instr_write_en,
  output logic             mem_write_en,
  output logic             cache_stall,
  output logic             timeout_err
);

  localparam int OFFW = $clog2(INW / 8);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t           state_reg;
  logic             sel_reg;          // 1 = data fill, 0 = instruction fetch
  logic             last_grant_reg;
  logic [ADDRW-1:0] addr_reg;
  logic [TW-1:0]    timer_reg;
  logic [INW-1:0]   line_reg;
  logic             timeout_err_reg;
  logic             dma_rd_req_reg;
  logic             ifetch_gnt_reg;
  logic             dmem_gnt_reg;
  logic             instr_we_reg;
  logic             mem_we_reg;

  logic             pick_dmem;
  logic [ADDRW-1:0] pick_addr;
  logic [ADDRW-1:0] aligned_addr;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick_dmem = 1'b0;
    if (ifetch_req && dmem_req) pick_dmem = ~last_grant_reg;
    else                        pick_dmem = dmem_req;
  end

  assign pick_addr    = pick_dmem ? dmem_addr : ifetch_addr;
  assign aligned_addr = {pick_addr[ADDRW-1:OFFW], {OFFW{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      sel_reg         <= 1'b0;
      last_grant_reg  <= 1'b1;
      addr_reg        <= '0;
      timer_reg       <= '0;
      line_reg        <= '0;
      timeout_err_reg <= 1'b0;
      dma_rd_req_reg  <= 1'b0;
      ifetch_gnt_reg  <= 1'b0;
      dmem_gnt_reg    <= 1'b0;
      instr_we_reg    <= 1'b0;
      mem_we_reg      <= 1'b0;
    end else begin
      ifetch_gnt_reg <= 1'b0;
      dmem_gnt_reg   <= 1'b0;
      instr_we_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ifetch_req || dmem_req) begin
            sel_reg        <= pick_dmem;
            addr_reg       <= aligned_addr;
            dma_rd_req_reg <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (dma_ready) begin
            dma_rd_req_reg <= 1'b0;
            timer_reg      <= '0;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          // A line arriving in the timeout cycle still completes the fill.
          if (rd_valid) begin
            line_reg       <= common_data_bus_in;
            instr_we_reg   <= ~sel_reg;
            mem_we_reg     <= sel_reg;
            ifetch_gnt_reg <= ~sel_reg;
            dmem_gnt_reg   <= sel_reg;
            state_reg      <= DELIVER;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            timeout_err_reg <= 1'b1;
            dma_rd_req_reg  <= 1'b1;
            state_reg       <= ISSUE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DELIVER: begin
          last_grant_reg <= sel_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dma_rd_req     = dma_rd_req_reg;
  assign dma_addr       = addr_reg;
  assign line_out       = line_reg;
  assign instr_write_en = instr_we_reg;
  assign mem_write_en   = mem_we_reg;
  assign ifetch_gnt     = ifetch_gnt_reg;
  assign dmem_gnt       = dmem_gnt_reg;
  assign timeout_err    = timeout_err_reg;
  assign cache_stall    = (state_reg != IDLE);

endmodule
